wb_stage: RTL

- Writeback stage of the RV32IF pipeline. It sits directly downstream of the memory stage.
- It consumes the memory stage's registered integer result/load data and FP-load data, plus results from the multi-cycle FPU.
- It drives the write ports of the integer and FP register files.
- A small FIFO holds FPU results that lose FP write-port arbitration to an flw; backpressure is ready/valid.

---
 rtl/rv32if_pkg.sv | 13 +
 rtl/wb_fpu_fifo.sv | 76 +++++++
 rtl/wb_stage.sv | 125 ++++++++++++
 3 files changed

// File: rtl/rv32if_pkg.sv
// Shared RV32IF pipeline definitions: datapath widths and the FP writeback
// source select used by the writeback stage.
package rv32if_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FPWB_NONE,
    FPWB_FLW,
    FPWB_BUF,
    FPWB_FPU
  } fp_wb_src_e;
endpackage

// File: rtl/wb_fpu_fifo.sv
// Small synchronous FIFO of {rd, data} FPU results that lost the FP write port.
// Also exposes each slot's rd and a valid mask so hazards can be checked.
module wb_fpu_fifo
  import rv32if_pkg::*;
#(
  parameter  int DEPTH = 2,
  parameter  int W     = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  push,
  input  logic [REG_ADDR_W-1:0]                 push_rd,
  input  logic [W-1:0]                          push_data,
  input  logic                                  pop,
  output logic [REG_ADDR_W-1:0]                 head_rd,
  output logic [W-1:0]                          head_data,
  output logic                                  full,
  output logic                                  empty,
  output logic [CNT_W-1:0]                      count,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]      entry_rd,
  output logic [DEPTH-1:0]                      entry_valid
);

  logic [REG_ADDR_W-1:0] rd_mem   [DEPTH];
  logic [W-1:0]          data_mem [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;

  // NOTE: storage is deliberately not reset; only pointers and count are, and
  // the count alone decides which slots hold live data.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail]   <= push_rd;
      data_mem[tail] <= push_data;
    end
  end

  // NOTE: state uses non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign head_rd   = rd_mem[head];
  assign head_data = data_mem[head];

  // A slot is live when its distance from head (mod DEPTH) is below the count.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    entry_valid = '0;
    entry_rd    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_rd[i]    = rd_mem[i];
      entry_valid[i] = CNT_W'(PTR_W'(PTR_W'(i) - head)) < count;
    end
  end

  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/wb_stage.sv
// RV32IF writeback stage: registered integer RF write port plus an arbitrated
// FP RF write port (flw > buffered FPU result > fresh FPU result).
module wb_stage #(
  parameter int XLEN          = rv32if_pkg::XLEN,
  parameter int FPU_BUF_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wb_enable_wb,
  input  logic [4:0]                       rd_wb,
  input  logic                             ld_wb,
  input  logic [XLEN-1:0]                  mem_data,
  input  logic [XLEN-1:0]                  result_out,
  input  logic                             flw_valid,
  input  logic [4:0]                       flw_rd,
  input  logic [XLEN-1:0]                  mem_data_out_f_wb,
  input  logic                             fpu_valid,
  input  logic [4:0]                       fpu_rd,
  input  logic [XLEN-1:0]                  fpu_result,
  output logic                             fpu_ready,
  output logic                             int_rf_we,
  output logic [4:0]                       int_rf_waddr,
  output logic [XLEN-1:0]                  int_rf_wdata,
  output logic                             fp_rf_we,
  output logic [4:0]                       fp_rf_waddr,
  output logic [XLEN-1:0]                  fp_rf_wdata,
  output logic [$clog2(FPU_BUF_DEPTH):0]   fp_buf_count,
  output logic                             waw_err
);
  import rv32if_pkg::*;

  fp_wb_src_e                                  src;
  logic                                        fpu_accept;
  logic                                        buf_push;
  logic                                        buf_pop;
  logic                                        buf_full;
  logic                                        buf_empty;
  logic [REG_ADDR_W-1:0]                       head_rd;
  logic [XLEN-1:0]                             head_data;
  logic [FPU_BUF_DEPTH-1:0][REG_ADDR_W-1:0]    entry_rd;
  logic [FPU_BUF_DEPTH-1:0]                    entry_valid;
  logic                                        waw_hit;

  wb_fpu_fifo #(
    .DEPTH (FPU_BUF_DEPTH),
    .W     (XLEN)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (buf_push),
    .push_rd     (fpu_rd),
    .push_data   (fpu_result),
    .pop         (buf_pop),
    .head_rd     (head_rd),
    .head_data   (head_data),
    .full        (buf_full),
    .empty       (buf_empty),
    .count       (fp_buf_count),
    .entry_rd    (entry_rd),
    .entry_valid (entry_valid)
  );

  // Ready depends only on occupancy, so a full buffer never passes through.
  assign fpu_ready  = !buf_full;
  assign fpu_accept = fpu_valid && fpu_ready;

  always_comb begin
    src = FPWB_NONE;
    if (flw_valid)       src = FPWB_FLW;
    else if (!buf_empty) src = FPWB_BUF;
    else if (fpu_valid)  src = FPWB_FPU;
  end

  assign buf_pop  = (src == FPWB_BUF);
  assign buf_push = fpu_accept && (src != FPWB_FPU);

  always_comb begin
    waw_hit = flw_valid && fpu_accept && (flw_rd == fpu_rd);
    for (int i = 0; i < FPU_BUF_DEPTH; i++) begin
      if (flw_valid && entry_valid[i] && (entry_rd[i] == flw_rd)) waw_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_rf_we    <= 1'b0;
      int_rf_waddr <= '0;
      int_rf_wdata <= '0;
    end else begin
      int_rf_we    <= wb_enable_wb && (rd_wb != '0);
      int_rf_waddr <= rd_wb;
      int_rf_wdata <= ld_wb ? mem_data : result_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fp_rf_we    <= 1'b0;
      fp_rf_waddr <= '0;
      fp_rf_wdata <= '0;
      waw_err     <= 1'b0;
    end else begin
      if (waw_hit) waw_err <= 1'b1;
      case (src)
        FPWB_FLW: begin
          fp_rf_we    <= 1'b1;
          fp_rf_waddr <= flw_rd;
          fp_rf_wdata <= mem_data_out_f_wb;
        end
        FPWB_BUF: begin
          fp_rf_we    <= 1'b1;
          fp_rf_waddr <= head_rd;
          fp_rf_wdata <= head_data;
        end
        FPWB_FPU: begin
          fp_rf_we    <= 1'b1;
          fp_rf_waddr <= fpu_rd;
          fp_rf_wdata <= fpu_result;
        end
        default: fp_rf_we <= 1'b0;
      endcase
    end
  end

endmodule
